// File: rtl/ps2_keyboard_fifo.sv
// PS/2 keyboard receiver for the VT52 terminal: framed receiver with parity,
// stop and timeout checks, scancode-set-2 decoder with Shift/Ctrl/Caps Lock,
// VT52 cursor-key sequences and a DEPTH-entry valid/ready output FIFO.
module ps2_keyboard_fifo #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 16384
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overflow,
    output logic       caps_lock
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    // ---------------- synchroniser and edge detect ----------------
    logic clk_s1_reg, clk_s2_reg, clk_prev_reg, dat_s1_reg, dat_s2_reg;
    logic fall;

    // Two-flop synchronisers plus a history flop for falling-edge detection
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            clk_s1_reg <= 1'b0; clk_s2_reg <= 1'b0; clk_prev_reg <= 1'b0;
            dat_s1_reg <= 1'b0; dat_s2_reg <= 1'b0;
        end else begin
            clk_s1_reg <= ps2_clk;    clk_s2_reg <= clk_s1_reg; clk_prev_reg <= clk_s2_reg;
            dat_s1_reg <= ps2_data;   dat_s2_reg <= dat_s1_reg;
        end
    end
    assign fall = clk_prev_reg & ~clk_s2_reg;

    // ---------------- frame receiver ----------------
    logic [3:0]    bit_cnt_reg;
    logic [7:0]    shift_reg, code_reg;
    logic          par_reg, code_stb_reg, frame_err_reg;
    logic [TW-1:0] to_cnt_reg;

    // Shift in start/data/parity/stop; a finished good byte strobes code_stb_reg
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            bit_cnt_reg <= '0; shift_reg <= '0; par_reg <= 1'b0; to_cnt_reg <= '0;
            code_reg <= '0; code_stb_reg <= 1'b0; frame_err_reg <= 1'b0;
        end else begin
            code_stb_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            if (fall) begin
                to_cnt_reg <= '0;
                if (bit_cnt_reg == 4'd0) begin
                    if (!dat_s2_reg) bit_cnt_reg <= 4'd1;
                    else             frame_err_reg <= 1'b1;
                end else if (bit_cnt_reg <= 4'd8) begin
                    shift_reg   <= {dat_s2_reg, shift_reg[7:1]};
                    bit_cnt_reg <= bit_cnt_reg + 4'd1;
                end else if (bit_cnt_reg == 4'd9) begin
                    par_reg     <= dat_s2_reg;
                    bit_cnt_reg <= 4'd10;
                end else begin
                    bit_cnt_reg <= 4'd0;
                    // odd parity: data plus parity bit carry an odd number of ones
                    if (dat_s2_reg && (^{shift_reg, par_reg})) begin
                        code_reg     <= shift_reg;
                        code_stb_reg <= 1'b1;
                    end else begin
                        frame_err_reg <= 1'b1;
                    end
                end
            end else if (bit_cnt_reg != 4'd0) begin
                if (to_cnt_reg == TW'(TIMEOUT - 1)) begin
                    bit_cnt_reg   <= 4'd0;
                    to_cnt_reg    <= '0;
                    frame_err_reg <= 1'b1;
                end else begin
                    to_cnt_reg <= to_cnt_reg + 1'b1;
                end
            end else begin
                to_cnt_reg <= '0;
            end
        end
    end

    // ---------------- keymap: {found, unshifted, shifted} ----------------
    function automatic logic [16:0] keymap(input logic [7:0] sc);
        logic [16:0] km;
        km = '0;
        case (sc)
            8'h1C: km = {1'b1, 8'h61, 8'h41};  8'h32: km = {1'b1, 8'h62, 8'h42};  8'h21: km = {1'b1, 8'h63, 8'h43};
            8'h23: km = {1'b1, 8'h64, 8'h44};  8'h24: km = {1'b1, 8'h65, 8'h45};  8'h2B: km = {1'b1, 8'h66, 8'h46};
            8'h34: km = {1'b1, 8'h67, 8'h47};  8'h33: km = {1'b1, 8'h68, 8'h48};  8'h43: km = {1'b1, 8'h69, 8'h49};
            8'h3B: km = {1'b1, 8'h6A, 8'h4A};  8'h42: km = {1'b1, 8'h6B, 8'h4B};  8'h4B: km = {1'b1, 8'h6C, 8'h4C};
            8'h3A: km = {1'b1, 8'h6D, 8'h4D};  8'h31: km = {1'b1, 8'h6E, 8'h4E};  8'h44: km = {1'b1, 8'h6F, 8'h4F};
            8'h4D: km = {1'b1, 8'h70, 8'h50};  8'h15: km = {1'b1, 8'h71, 8'h51};  8'h2D: km = {1'b1, 8'h72, 8'h52};
            8'h1B: km = {1'b1, 8'h73, 8'h53};  8'h2C: km = {1'b1, 8'h74, 8'h54};  8'h3C: km = {1'b1, 8'h75, 8'h55};
            8'h2A: km = {1'b1, 8'h76, 8'h56};  8'h1D: km = {1'b1, 8'h77, 8'h57};  8'h22: km = {1'b1, 8'h78, 8'h58};
            8'h35: km = {1'b1, 8'h79, 8'h59};  8'h1A: km = {1'b1, 8'h7A, 8'h5A};
            8'h0E: km = {1'b1, 8'h60, 8'h7E};  8'h16: km = {1'b1, 8'h31, 8'h21};  8'h1E: km = {1'b1, 8'h32, 8'h40};
            8'h26: km = {1'b1, 8'h33, 8'h23};  8'h25: km = {1'b1, 8'h34, 8'h24};  8'h2E: km = {1'b1, 8'h35, 8'h25};
            8'h36: km = {1'b1, 8'h36, 8'h5E};  8'h3D: km = {1'b1, 8'h37, 8'h26};  8'h3E: km = {1'b1, 8'h38, 8'h2A};
            8'h46: km = {1'b1, 8'h39, 8'h28};  8'h45: km = {1'b1, 8'h30, 8'h29};  8'h4E: km = {1'b1, 8'h2D, 8'h5F};
            8'h55: km = {1'b1, 8'h3D, 8'h2B};  8'h5D: km = {1'b1, 8'h5C, 8'h7C};  8'h54: km = {1'b1, 8'h5B, 8'h7B};
            8'h5B: km = {1'b1, 8'h5D, 8'h7D};  8'h4C: km = {1'b1, 8'h3B, 8'h3A};  8'h52: km = {1'b1, 8'h27, 8'h22};
            8'h41: km = {1'b1, 8'h2C, 8'h3C};  8'h49: km = {1'b1, 8'h2E, 8'h3E};  8'h4A: km = {1'b1, 8'h2F, 8'h3F};
            8'h76: km = {1'b1, 8'h1B, 8'h1B};  8'h0D: km = {1'b1, 8'h09, 8'h09};  8'h66: km = {1'b1, 8'h08, 8'h08};
            8'h29: km = {1'b1, 8'h20, 8'h20};  8'h5A: km = {1'b1, 8'h0D, 8'h0D};
            default: km = '0;
        endcase
        return km;
    endfunction

    // ---------------- decoder ----------------
    logic ext_reg, brk_reg, lshift_reg, rshift_reg, lctrl_reg, rctrl_reg, caps_reg, caps_held_reg;
    logic        key_push, cur_req, is_letter, shift_on, ctrl_on;
    logic [7:0]  key_char, cur_char;
    logic [16:0] km;

    // Translate a completed make code into a character or cursor request
    always_comb begin
        key_push  = 1'b0;
        key_char  = 8'h00;
        cur_req   = 1'b0;
        cur_char  = 8'h00;
        km        = keymap(code_reg);
        is_letter = (km[15:8] >= 8'h61) && (km[15:8] <= 8'h7A);
        shift_on  = lshift_reg | rshift_reg;
        ctrl_on   = lctrl_reg | rctrl_reg;
        if (code_stb_reg && code_reg != 8'hE0 && code_reg != 8'hF0 && !brk_reg) begin
            if (ext_reg) begin
                case (code_reg)
                    8'h75: begin cur_req = 1'b1; cur_char = 8'h41; end
                    8'h72: begin cur_req = 1'b1; cur_char = 8'h42; end
                    8'h74: begin cur_req = 1'b1; cur_char = 8'h43; end
                    8'h6B: begin cur_req = 1'b1; cur_char = 8'h44; end
                    default: ;
                endcase
            end else if (km[16]) begin
                key_push = 1'b1;
                if (is_letter && ctrl_on)          key_char = km[15:8] & 8'h1F;
                else if (is_letter)                key_char = (shift_on ^ caps_reg) ? km[7:0] : km[15:8];
                else                               key_char = shift_on ? km[7:0] : km[15:8];
            end
        end
    end

    // Prefix flags, modifier state and Caps Lock toggling
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ext_reg <= 1'b0; brk_reg <= 1'b0; lshift_reg <= 1'b0; rshift_reg <= 1'b0;
            lctrl_reg <= 1'b0; rctrl_reg <= 1'b0; caps_reg <= 1'b0; caps_held_reg <= 1'b0;
        end else if (frame_err_reg) begin
            ext_reg <= 1'b0; brk_reg <= 1'b0;
        end else if (code_stb_reg) begin
            if (code_reg == 8'hE0)      ext_reg <= 1'b1;
            else if (code_reg == 8'hF0) brk_reg <= 1'b1;
            else begin
                ext_reg <= 1'b0; brk_reg <= 1'b0;
                if (code_reg == 8'h12 && !ext_reg) lshift_reg <= !brk_reg;
                if (code_reg == 8'h59 && !ext_reg) rshift_reg <= !brk_reg;
                if (code_reg == 8'h14 &&  ext_reg) rctrl_reg  <= !brk_reg;
                if (code_reg == 8'h14 && !ext_reg) lctrl_reg  <= !brk_reg;
                if (code_reg == 8'h58 && !ext_reg) begin
                    if (brk_reg) caps_held_reg <= 1'b0;
                    else begin
                        caps_held_reg <= 1'b1;
                        if (!caps_held_reg) caps_reg <= ~caps_reg;
                    end
                end
            end
        end
    end

    // ---------------- FIFO ----------------
    logic [7:0]    mem [DEPTH];
    logic [AW:0]   wr_ptr_reg, rd_ptr_reg, wr_ptr_next, rd_ptr_next, count, count_next;
    logic [7:0]    pend_char_reg, push_data, data_reg, data_next;
    logic          pend_reg, pend_next, valid_reg, overflow_reg, ov_next;
    logic          push_req, push_ok, pop, full;

    // Push arbitration, overflow detection and next FIFO head
    always_comb begin
        count     = wr_ptr_reg - rd_ptr_reg;
        full      = (count == (AW+1)'(DEPTH));
        pop       = valid_reg & ready;
        push_req  = 1'b0;
        push_data = 8'h00;
        pend_next = 1'b0;
        ov_next   = 1'b0;
        if (pend_reg) begin
            push_req  = 1'b1;
            push_data = pend_char_reg;
        end else if (cur_req) begin
            // free space is judged before any same-cycle pop
            if (count <= (AW+1)'(DEPTH - 2)) begin
                push_req  = 1'b1;
                push_data = 8'h1B;
                pend_next = 1'b1;
            end else begin
                ov_next = 1'b1;
            end
        end else if (key_push) begin
            push_req  = 1'b1;
            push_data = key_char;
        end
        push_ok = push_req & (~full | pop);
        if (push_req && !push_ok) ov_next = 1'b1;
        wr_ptr_next = wr_ptr_reg + {{AW{1'b0}}, push_ok};
        rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, pop};
        count_next  = wr_ptr_next - rd_ptr_next;
        if (count_next == '0)
            data_next = 8'h00;
        else if (push_ok && wr_ptr_reg[AW-1:0] == rd_ptr_next[AW-1:0])
            data_next = push_data;
        else
            data_next = mem[rd_ptr_next[AW-1:0]];
    end

    // Storage array write port
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

    // Pointers, registered head/valid, pending cursor byte and overflow pulse
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr_reg <= '0; rd_ptr_reg <= '0; data_reg <= 8'h00; valid_reg <= 1'b0;
            pend_reg <= 1'b0; pend_char_reg <= 8'h00; overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            data_reg     <= data_next;
            valid_reg    <= (count_next != '0);
            pend_reg     <= pend_next;
            overflow_reg <= ov_next;
            if (pend_next) pend_char_reg <= cur_char;
        end
    end

    assign data      = data_reg;
    assign valid     = valid_reg;
    assign frame_err = frame_err_reg;
    assign overflow  = overflow_reg;
    assign caps_lock = caps_reg;
endmodule

// File: tb/tb_ps2_keyboard_fifo.sv
// Directed bench for ps2_keyboard_fifo: bit-bangs PS/2 frames and checks
// the ASCII bytes leaving the FIFO, error/overflow pulses and Caps Lock.
module tb_ps2_keyboard_fifo;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 100;

    logic       clk = 1'b0, clr = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1, ready = 1'b0;
    logic [7:0] data;
    logic       valid, frame_err, overflow, caps_lock;

    int total = 0, bad = 0;
    int cyc = 0, fe_cnt = 0, ov_cnt = 0;
    logic [7:0] q[$];
    int         qt[$];

    ps2_keyboard_fifo #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .clr(clr), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .data(data), .valid(valid), .ready(ready),
        .frame_err(frame_err), .overflow(overflow), .caps_lock(caps_lock)
    );

    always #5 clk = ~clk;

    // cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // log every accepted byte and count error/overflow pulse cycles
    always @(negedge clk) begin
        if (valid && ready) begin
            q.push_back(data);
            qt.push_back(cyc);
            $display("pop data=%02h cycle=%0d", data, cyc);
        end
        if (frame_err) fe_cnt = fe_cnt + 1;
        if (overflow)  ov_cnt = ov_cnt + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // send the first nbits bits of a frame (start, 8 data LSB first, parity, stop)
    task automatic send_frame(input logic [7:0] code, input bit bad_par, input int nbits);
        logic [10:0] bits;
        bits = {1'b1, (~(^code)) ^ bad_par, code, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            tick; tick;
            ps2_clk = 1'b0;
            idle(4);
            ps2_clk = 1'b1;
            tick; tick;
        end
        ps2_data = 1'b1;
    endtask

    task automatic press(input logic [7:0] code);
        send_frame(code, 1'b0, 11);
    endtask

    initial begin
        int qb, fb, ob;
        // reset state
        idle(3);
        chk("rst_data", data, 8'h00);
        chk("rst_valid", valid, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_caps", caps_lock, 1'b0);
        clr = 1'b0;
        idle(3);

        // 1C then F0 1C: one 'a', valid two cycles after the stop edge is detected
        ready = 1'b1; qb = q.size(); fb = fe_cnt;
        send_frame(8'h1C, 1'b0, 10);
        ps2_data = 1'b1; tick; tick;
        ps2_clk = 1'b0;
        tick; tick; tick;
        chk("lat_valid_n1", valid, 1'b0);
        tick;
        chk("lat_valid_n2", valid, 1'b1);
        chk("lat_data_n2", data, 8'h61);
        ps2_clk = 1'b1; tick; tick;
        press(8'hF0); press(8'h1C); idle(5);
        chk("a_count", q.size() - qb, 1);
        chk("a_byte", q[qb], 8'h61);
        chk("a_no_err", fe_cnt - fb, 0);

        // Shift: 12 1C F0 1C F0 12 1C -> 41 61
        qb = q.size();
        press(8'h12); press(8'h1C); press(8'hF0); press(8'h1C);
        press(8'hF0); press(8'h12); press(8'h1C); idle(5);
        chk("shift_count", q.size() - qb, 2);
        chk("shift_b0", q[qb], 8'h41);
        chk("shift_b1", q[qb+1], 8'h61);

        // Caps Lock with typematic repeat: 58 58 F0 58 1C -> caps on, 41
        qb = q.size();
        press(8'h58); press(8'h58); press(8'hF0); press(8'h58); press(8'h1C); idle(5);
        chk("caps_on", caps_lock, 1'b1);
        chk("caps_count", q.size() - qb, 1);
        chk("caps_byte", q[qb], 8'h41);

        // Ctrl+C overrides caps -> 03
        qb = q.size();
        press(8'h14); press(8'h21); press(8'hF0); press(8'h14); idle(5);
        chk("ctrl_count", q.size() - qb, 1);
        chk("ctrl_byte", q[qb], 8'h03);
        press(8'h58); press(8'hF0); press(8'h58); idle(3);
        chk("caps_off", caps_lock, 1'b0);

        // cursor up E0 75 -> 1B 41 popped on consecutive cycles
        qb = q.size();
        press(8'hE0); press(8'h75); idle(5);
        chk("cur_count", q.size() - qb, 2);
        chk("cur_b0", q[qb], 8'h1B);
        chk("cur_b1", q[qb+1], 8'h41);
        chk("cur_gap", qt[qb+1] - qt[qb], 1);

        // bad parity, then timeout, then recovery
        qb = q.size(); fb = fe_cnt;
        send_frame(8'h1C, 1'b1, 11); idle(5);
        chk("par_err", fe_cnt - fb, 1);
        chk("par_nopush", q.size() - qb, 0);
        send_frame(8'h1C, 1'b0, 6);
        idle(TIMEOUT + 1);
        chk("to_err", fe_cnt - fb, 2);
        press(8'h1C); idle(5);
        chk("to_recover_count", q.size() - qb, 1);
        chk("to_recover_byte", q[qb], 8'h61);

        // overflow: DEPTH+1 presses with ready low
        ready = 1'b0; qb = q.size(); ob = ov_cnt;
        for (int i = 0; i < DEPTH + 1; i++) press(8'h1C);
        idle(3);
        chk("ovf_pulse", ov_cnt - ob, 1);
        chk("ovf_valid", valid, 1'b1);
        chk("ovf_head", data, 8'h61);
        // remove one entry, then a cursor key with one slot free is dropped
        ready = 1'b1; tick; ready = 1'b0;
        press(8'hE0); press(8'h72); idle(3);
        chk("cur_drop_pulse", ov_cnt - ob, 2);
        ready = 1'b1; idle(DEPTH + 6);
        chk("ovf_drain_count", q.size() - qb, DEPTH);
        for (int i = 0; i < DEPTH; i++) chk("ovf_drain_byte", q[qb+i], 8'h61);

        // full FIFO with a pop in the push cycle: push accepted, no overflow
        ready = 1'b0; qb = q.size(); ob = ov_cnt;
        for (int i = 0; i < DEPTH; i++) press(8'h1C);
        send_frame(8'h32, 1'b0, 10);
        ps2_data = 1'b1; tick; tick;
        ps2_clk = 1'b0;
        tick; tick; tick;
        ready = 1'b1; tick; ready = 1'b0;
        ps2_clk = 1'b1; idle(4);
        chk("full_pop_noovf", ov_cnt - ob, 0);
        ready = 1'b1; idle(DEPTH + 6);
        chk("full_pop_count", q.size() - qb, DEPTH + 1);
        chk("full_pop_first", q[qb], 8'h61);
        chk("full_pop_last", q[qb+DEPTH], 8'h62);

        // clr mid-frame with caps on and data queued
        ready = 1'b0;
        press(8'h58); press(8'hF0); press(8'h58); press(8'h1C);
        send_frame(8'h1C, 1'b0, 5);
        chk("pre_clr_valid", valid, 1'b1);
        chk("pre_clr_caps", caps_lock, 1'b1);
        clr = 1'b1; #1;
        chk("clr_data", data, 8'h00);
        chk("clr_valid", valid, 1'b0);
        chk("clr_caps", caps_lock, 1'b0);
        chk("clr_frame_err", frame_err, 1'b0);
        chk("clr_overflow", overflow, 1'b0);
        tick; clr = 1'b0; idle(2);
        ready = 1'b1; qb = q.size();
        press(8'h1C); idle(5);
        chk("post_clr_count", q.size() - qb, 1);
        chk("post_clr_byte", q[qb], 8'h61);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
